// File: rtl/xbar_cfg_pkg.sv
// xbar_cfg_pkg: shared state encoding, word width and checksum step for the chain loader
package xbar_cfg_pkg;
   localparam int W_DEF = 32;
   typedef enum logic [1:0] {IDLE, LOAD, ROTATE, CHECK} state_t;
   function automatic logic [W_DEF-1:0] chk_step(input logic [W_DEF-1:0] c, input logic [W_DEF-1:0] w);
      return {c[W_DEF-2:0], c[W_DEF-1]} ^ w;
   endfunction
endpackage

// File: rtl/xbar_cfg_chk.sv
// xbar_cfg_chk: running rotate-xor checksum register with clear and step enable
module xbar_cfg_chk
   import xbar_cfg_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic         clk,
   input  logic         res,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] word,
   output logic [W-1:0] chk
);
   logic [W-1:0] chk_q, chk_d;
   always_comb chk_d = clr ? '0 : en ? ({chk_q[W-2:0], chk_q[W-1]} ^ word) : chk_q;
   always_ff @(posedge clk or posedge res)
      if (res) chk_q <= '0;
      else     chk_q <= chk_d;
   assign chk = chk_q;
endmodule

// File: rtl/xbar_cfg_loader.sv
// xbar_cfg_loader: loads a crossbar program shift chain and verifies it by a non-destructive rotate
module xbar_cfg_loader
   import xbar_cfg_pkg::*;
#(
   parameter int CHAIN_LEN = 72,
   parameter int W         = W_DEF
) (
   input  logic         clk,
   input  logic         res,
   input  logic         start_load,
   input  logic         start_verify,
   input  logic [W-1:0] cfg_data,
   input  logic         cfg_valid,
   output logic         cfg_ready,
   output logic [W-1:0] prog_i,
   output logic         prog_shft,
   input  logic [W-1:0] prog_o,
   output logic         busy,
   output logic         done,
   output logic         err,
   output logic [W-1:0] golden_chk
);
   localparam int CW = $clog2(CHAIN_LEN + 1);
   localparam logic [CW-1:0] LEN = CW'(CHAIN_LEN);

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [W-1:0]   data_q, data_d, golden_q, golden_d;
   logic           shft_q, shft_d, gvld_q, gvld_d, done_q, done_d, err_q, err_d;
   logic           accept, chk_clr, chk_en;
   logic [W-1:0]   chk_word, run_chk;

   assign cfg_ready  = state_q == LOAD && cnt_q < LEN;
   assign accept     = cfg_ready && cfg_valid;
   // during rotate the chain feeds itself so its contents survive the readback
   assign prog_shft  = state_q == ROTATE || (state_q == LOAD && shft_q);
   assign prog_i     = state_q == ROTATE ? prog_o : data_q;
   assign chk_word   = state_q == ROTATE ? prog_o : cfg_data;
   assign chk_en     = accept || state_q == ROTATE;
   assign busy       = state_q != IDLE;
   assign done       = done_q;
   assign err        = err_q;
   assign golden_chk = golden_q;

   xbar_cfg_chk #(.W(W)) u_chk (
      .clk (clk),
      .res (res),
      .clr (chk_clr),
      .en  (chk_en),
      .word(chk_word),
      .chk (run_chk)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      data_d   = data_q;
      shft_d   = 1'b0;
      golden_d = golden_q;
      gvld_d   = gvld_q;
      done_d   = 1'b0;
      err_d    = err_q;
      chk_clr  = 1'b0;
      case (state_q)
         IDLE:
            if (start_load) begin
               state_d = LOAD;
               cnt_d   = '0;
               err_d   = 1'b0;
               gvld_d  = 1'b0;
               chk_clr = 1'b1;
            end else if (start_verify && gvld_q) begin
               state_d = ROTATE;
               cnt_d   = '0;
               err_d   = 1'b0;
               chk_clr = 1'b1;
            end else if (start_verify) begin
               err_d  = 1'b1;
               done_d = 1'b1;
            end
         LOAD:
            if (accept) begin
               data_d = cfg_data;
               shft_d = 1'b1;
               cnt_d  = cnt_q + 1'b1;
            end else if (cnt_q == LEN && !shft_q) begin
               golden_d = run_chk;
               gvld_d   = 1'b1;
               done_d   = 1'b1;
               state_d  = IDLE;
            end
         ROTATE: begin
            cnt_d   = cnt_q + 1'b1;
            state_d = cnt_q == LEN - 1'b1 ? CHECK : ROTATE;
         end
         CHECK: begin
            err_d   = run_chk != golden_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge res)
      if (res) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         data_q   <= '0;
         shft_q   <= 1'b0;
         golden_q <= '0;
         gvld_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         shft_q   <= shft_d;
         golden_q <= golden_d;
         gvld_q   <= gvld_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
endmodule
